// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and constants for the round-robin register write arbiter.
package reg_write_arbiter_pkg;
    localparam int WIDTH = 4;
    localparam int N_REQ = 4;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2
    } state_t;
endpackage

// File: rtl/reg_write_arbiter_register.sv
// Generic clock-enabled register with synchronous active-high clear.
module register #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one of four requesters a write into a shared 4-bit register.
//   state | meaning
//   IDLE  | arbitrate; latch winner into owner when any req is high
//   LOAD  | register enable high, captures data of owner
//   ACK   | ack[owner] pulsed, ptr advances past owner, wr_cnt increments
module reg_write_arbiter #(
    parameter int WIDTH = 4,
    parameter int N_REQ = 4
) (
    input  logic                                   CLK,
    input  logic                                   RST,
    input  logic [N_REQ-1:0]                       req,
    input  logic [N_REQ*WIDTH-1:0]                 data,
    output logic [N_REQ-1:0]                       ack,
    output logic [WIDTH-1:0]                       Dout,
    output logic                                   busy,
    output logic [1:0]                             owner,
    output logic [reg_write_arbiter_pkg::CNT_W-1:0] wr_cnt
);
    import reg_write_arbiter_pkg::*;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       ptr;
    logic [1:0]       winner;
    logic             reg_en;
    logic [WIDTH-1:0] reg_d;

    // First set request at or above p, wrapping; scanning downward lets the nearest one win.
    function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = p;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    assign winner = rr_pick(req, ptr);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = LOAD;
            LOAD:    state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        reg_en = 1'b0;
        reg_d  = data[{owner, 2'b00} +: WIDTH];
        ack    = '0;
        busy   = (state != IDLE);
        case (state)
            LOAD:    reg_en = 1'b1;
            ACK:     ack[owner] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr    <= '0;
            owner  <= '0;
            wr_cnt <= '0;
        end else begin
            if (state == IDLE && |req) begin
                owner <= winner;
            end
            if (state == ACK) begin
                ptr    <= owner + 2'd1;
                wr_cnt <= wr_cnt + CNT_W'(1);
            end
        end
    end

    register #(.WIDTH(WIDTH)) u_shared_reg (
        .clk (CLK),
        .rst (RST),
        .en  (reg_en),
        .d   (reg_d),
        .q   (Dout)
    );

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench: a transaction-level model predicts each write; a negedge monitor checks it.
module tb_reg_write_arbiter;

    logic        CLK;
    logic        RST;
    logic [3:0]  req;
    logic [15:0] data;
    logic [3:0]  ack;
    logic [3:0]  Dout;
    logic        busy;
    logic [1:0]  owner;
    logic [7:0]  wr_cnt;

    reg_write_arbiter dut (
        .CLK    (CLK),
        .RST    (RST),
        .req    (req),
        .data   (data),
        .ack    (ack),
        .Dout   (Dout),
        .busy   (busy),
        .owner  (owner),
        .wr_cnt (wr_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        int       due;
        int       idx;
        int       val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   ptr_m    = 0;
    int   free_m   = 0;
    int   busy_lo  = 0;
    int   busy_hi  = -1;
    bit   m_rst    = 1'b1;
    int   exp_cnt  = 0;
    int   exp_dout = 0;
    int   errors   = 0;
    int   checks   = 0;

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    // Reference model: arbiter is free three cycles after each grant; winner is the
    // first requester at or after the rotating pointer; result appears two cycles later.
    always @(posedge CLK) begin
        if (RST) begin
            ptr_m   = 0;
            exp_q.delete();
            free_m  = cyc + 1;
            busy_hi = -1;
            m_rst   = 1'b1;
        end else begin
            m_rst = 1'b0;
            if (cyc >= free_m && req != 4'b0) begin
                int w;
                exp_t e;
                w = -1;
                for (int k = 0; k < 4; k++) begin
                    int j;
                    j = (ptr_m + k) % 4;
                    if (w < 0 && req[j]) w = j;
                end
                e.due = cyc + 2;
                e.idx = w;
                e.val = (data >> (4 * w)) & 16'hF;
                exp_q.push_back(e);
                ptr_m   = (w + 1) % 4;
                free_m  = cyc + 3;
                busy_lo = cyc + 1;
                busy_hi = cyc + 2;
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge CLK) begin
        if (cyc > 0) begin
            if (m_rst) begin
                exp_cnt  = 0;
                exp_dout = 0;
                chk("rst_ack", ack, 0);
                chk("rst_busy", busy, 0);
                chk("rst_dout", Dout, 0);
                chk("rst_wr_cnt", wr_cnt, 0);
                chk("rst_owner", owner, 0);
            end else begin
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ack", ack, 1 << e.idx);
                    chk("owner", owner, e.idx);
                    chk("dout_ack", Dout, e.val);
                    chk("wr_cnt_ack", wr_cnt, exp_cnt);
                    exp_dout = e.val;
                    exp_cnt  = (exp_cnt + 1) % 256;
                end else begin
                    chk("ack_idle", ack, 0);
                    chk("dout_hold", Dout, exp_dout);
                    chk("wr_cnt", wr_cnt, exp_cnt);
                end
                chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
    endtask

    initial begin
        RST  = 1'b1;
        req  = 4'b1111;
        data = 16'($urandom);
        tick(2);
        RST = 1'b0;
        req = 4'b0000;
        tick(2);

        // single write from requester 2
        data[11:8] = 4'hA;
        req        = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (ack[2]) break;
        end
        req = 4'b0000;
        tick(3);

        // round robin with everyone requesting
        req  = 4'b1111;
        data = 16'h8765;
        do_reset();
        tick(15);
        req = 4'b0000;
        tick(3);

        // request dropped during LOAD still completes
        data[7:4] = 4'h3;
        req       = 4'b0010;
        tick(1);
        req = 4'b0000;
        tick(4);

        // reset during LOAD aborts the write
        do_reset();
        data[15:12] = 4'hF;
        req         = 4'b1000;
        tick(1);
        RST = 1'b1;
        req = 4'b0000;
        tick(1);
        RST = 1'b0;
        tick(3);

        // 256 back-to-back writes to wrap the counter
        data = 16'($urandom);
        req  = 4'b1111;
        do_reset();
        tick(256 * 3 + 2);
        req = 4'b0000;
        tick(3);

        // random traffic: requesters hold until ack, then sometimes keep requesting
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    if (ack[i] && ($urandom % 2 == 0)) req[i] = 1'b0;
                end else if ($urandom % 4 == 0) begin
                    data[4*i +: 4] = 4'($urandom);
                    req[i]         = 1'b1;
                end else begin
                    data[4*i +: 4] = 4'($urandom);
                end
            end
            tick(1);
        end
        req = 4'b0000;
        tick(6);

        chk("pending_writes", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameters SHALL be as follows; both are fixed, and other values are unsupported.
- WIDTH, 4, data width of the shared register.
- N_REQ, 4, number of requesters.

REQ-002 Ports SHALL be as follows:
- CLK  in  1  single system clock; all state updates on its rising edge.
- RST  in  1  reset; synchronous, active-high.
- req  in  4  per-requester write request, level.
- data  in  16  write data; requester i on bits [4i+3:4i].
- ack  out  4  per-requester one-cycle completion pulse.
- Dout  out  4  current content of the shared 4-bit register.
- busy  out  1  high whenever the FSM is not IDLE.
- owner  out  2  index of the current or last granted requester.
- wr_cnt  out  8  count of completed writes.

REQ-003 The block SHALL have exactly one clock, CLK; reset RST SHALL be synchronous and active-high.

Function
REQ-004 The FSM SHALL have three states: IDLE, LOAD and ACK.
REQ-005 Transitions SHALL be IDLE->LOAD when any req bit is high, LOAD->ACK unconditionally, and ACK->IDLE unconditionally.
REQ-006 In IDLE, the winner SHALL be the first set req bit searching upward from pointer ptr, wrapping 3->0.
- The winner is latched into owner on the IDLE->LOAD edge.
REQ-007 In LOAD, the register enable SHALL be 1 for exactly one cycle, with register input = data[owner] sampled that cycle.
- The register enable is 0 in all other states.
REQ-008 Dout SHALL show the new value in the ACK cycle, i.e. 2 cycles after the IDLE cycle in which req was first seen.
REQ-009 ack[owner] SHALL be 1 for exactly the ACK cycle; all other ack bits are 0, and at most one ack bit is ever high.
REQ-010 On the ACK->IDLE edge, ptr SHALL become owner+1 mod 4 (wrap 3->0).
REQ-011 On the ACK->IDLE edge, wr_cnt SHALL increment by 1 and wrap 255->0.
REQ-012 Requesters SHALL hold req and data stable until ack.
- If req drops during LOAD or ACK, the write still completes and ack is still pulsed.
- No request cancellation is supported.
REQ-013 A requester holding req high after its ack SHALL be re-arbitrated in the next IDLE cycle at the lowest priority.
REQ-014 Minimum spacing between successive writes SHALL be 3 cycles; one IDLE cycle always separates transactions.
REQ-015 busy SHALL be 1 in LOAD and ACK, and 0 in IDLE.
REQ-016 Simultaneous requests SHALL be served strictly round-robin; no requester waits more than 3 transactions.

Reset
REQ-017 While RST=1 at a rising edge, the block SHALL reset as follows, overriding any in-flight transaction with no write completion:
- state = IDLE
- ptr = 0
- owner = 0
- ack = 0
- busy = 0
- wr_cnt = 0
- Dout = 0
REQ-018 The first arbitration SHALL occur in the first cycle after RST deasserts.

Structure
REQ-019 A shared package SHALL hold the FSM state enum (IDLE, LOAD, ACK) and the constants WIDTH=4, N_REQ=4 and CNT_W=8.
REQ-020 The shared register SHALL be one instance of the team's existing 4-bit clock-enabled register block (module register).
- Its clock and reset come from CLK/RST; its enable and input come from the FSM.
- Dout is its output.
REQ-021 Round-robin selection SHALL be a combinational function local to this module; no further sub-modules are used.

Verification
REQ-022 Reset: hold RST=1 for 2 cycles with req=4'b1111 -> Dout=0, ack=0, busy=0, wr_cnt=0, owner=0 throughout.
REQ-023 Single write: req=4'b0100 with data[11:8]=4'hA from cycle 0 -> busy=1 in cycles 1-2, ack=4'b0100 in cycle 2 only, Dout=4'hA from cycle 2, wr_cnt=1 from cycle 3.
REQ-024 Round-robin: req=4'b1111 held constantly after reset with data[i]=i+5 -> owner sequence 0,1,2,3,0, Dout sequence 5,6,7,8,5, acks 3 cycles apart.
REQ-025 Drop during LOAD: req[1]=1 with data[7:4]=4'h3, req deasserted in the LOAD cycle -> Dout=3 and ack[1] still pulsed, then IDLE.
REQ-026 Reset mid-operation: assert RST in the LOAD cycle of a write of 4'hF -> no ack, Dout=0, state IDLE, wr_cnt unchanged at 0.
REQ-027 Counter wrap: 256 back-to-back writes -> wr_cnt reads 255 after write 255 and 0 after write 256.
